iter_alu: RTL and testbench
===========================

Name: iter_alu

Overview:
- Multi-cycle, parametrised successor to the single-cycle rv32i ALU.
- Keeps AND/OR/ADD/SUB and adds iterative unsigned multiply and divide (MUL, MULHU, DIVU, REMU).
- Sits in the execute stage behind a valid/ready handshake, so the core can stall on long operations.
- Non-pipelined: one operation in flight at a time.

Parameters:
- XLEN, 32, operand/result width in bits (>= 4).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- alu_op  input  4  operation select, sampled on accept
- in_a  input  XLEN  operand a, sampled on accept
- in_b  input  XLEN  operand b, sampled on accept
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- result  output  XLEN  registered result, stable while out_valid
- zero  output  1  1 when result == 0, qualified by out_valid
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- busy  output  1  iterative operation in progress

Behaviour:
- Reset: asynchronous, active-low; clk and rst_n are the only clock and reset.
  - state=IDLE; result=0, zero=1, out_valid=0, busy=0, in_ready=1; counter and working registers cleared.
- Op encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 1000 MUL (low XLEN bits of a*b), 1001 MULHU (high XLEN bits, unsigned).
  - 1010 DIVU, 1011 REMU.
  - Any other code is a fast op with result 0.
- Accept: a request is accepted on a rising edge where in_valid && in_ready.
- in_ready = (state == IDLE).
- States:
  - IDLE:
    - Fast op (logic/add/sub/undefined), or DIVU/REMU with in_b == 0: compute and register result, go to DONE. Latency 1: out_valid high the cycle after accept.
    - Other MUL/DIV op: latch operands, counter = 0, go to BUSY.
  - BUSY:
    - Performs one shift-add (MUL/MULHU) or one restoring shift-subtract (DIVU/REMU) step per cycle.
    - MUL/MULHU use a 2*XLEN-bit product register; DIVU/REMU use an XLEN-bit partial remainder with one guard bit.
    - After exactly XLEN steps, load the selected result and go to DONE.
    - out_valid rises XLEN+1 cycles after accept.
    - busy = 1 only in BUSY.
  - DONE:
    - out_valid = 1; result and zero held stable.
    - On out_ready: go to IDLE, drop out_valid. in_ready rises the same cycle out_valid falls.
    - No new request is taken in the cycle of the handshake.
- Arithmetic: all unsigned, modulo 2^XLEN; ADD/SUB carry and borrow are discarded.
- Divide by zero (RISC-V semantics, fast path):
  - DIVU -> all ones.
  - REMU -> in_a.
- No overflow case exists for unsigned divide.
- zero is computed from the registered result and is valid only while out_valid.
- Boundaries:
  - in_valid while not IDLE is ignored; the source must hold it until in_ready.
  - Operand/op changes after accept have no effect; operands are latched.
  - out_ready while not DONE is ignored.
  - rst_n low mid-BUSY or mid-DONE: immediate return to reset values; the pending result is discarded and no out_valid is produced.
  - MUL with in_a or in_b == 0 still takes the full XLEN iterations (constant latency).

Test Plan:
- Reset mid-op, XLEN=32:
  - Accept MUL 0xFFFFFFFF x 2; assert rst_n=0 on cycle 10 of BUSY -> out_valid=0, result=0, zero=1, in_ready=1 asynchronously, before the next edge.
  - Subsequent ADD 5+7 -> result 12.
- Fast ops with backpressure:
  - ADD 0xFFFFFFFF+1 -> result 0, zero=1, out_valid on cycle +1.
  - SUB 3-5 -> 0xFFFFFFFE.
  - AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0.
  - OR 0x1|0x2 -> 0x3.
  - Undefined op 0101 -> 0.
  - Hold out_ready=0 for 5 cycles -> result stable, in_ready=0 throughout.
- Multiply:
  - MUL 0x12345678 x 0x10 -> 0x23456780.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - Check out_valid exactly 33 cycles after accept and busy=1 for 32 cycles.
- Divide:
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - DIVU 0x80000000/1 -> 0x80000000.
  - REMU 6/3 -> 0 with zero=1.
- Divide by zero:
  - DIVU 0x1234/0 -> 0xFFFFFFFF, latency 1.
  - REMU 0x1234/0 -> 0x1234, latency 1.
- Handshake and parameter:
  - in_valid held high with a changing op while BUSY -> ignored; the operation completes with the latched operands.
  - Back-to-back requests: the second is accepted only after the out_ready handshake.
  - Rerun the multiply and divide scenarios with XLEN=8 (MUL 0xFF x 0xFF -> 0x01, MULHU -> 0xFE).

Source files
------------

// File: rtl/iter_alu.sv
// Multi-cycle execute-stage ALU: single-cycle logic/add/sub plus iterative unsigned
// MUL/MULHU (shift-add) and DIVU/REMU (restoring division) behind valid/ready handshakes.
module iter_alu #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  state_e                state_q, state_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic [XLEN-1:0]       opnd_q, opnd_d;   // multiplicand or divisor
  logic [2*XLEN-1:0]     prod_q, prod_d;
  logic [XLEN-1:0]       rem_q, rem_d;
  logic [XLEN-1:0]       quo_q, quo_d;

  logic [XLEN:0]         mul_sum;
  logic [2*XLEN-1:0]     prod_step;
  logic [XLEN:0]         rem_shift;
  logic [XLEN:0]         trial;
  logic [XLEN-1:0]       rem_step;
  logic [XLEN-1:0]       quo_step;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_BUSY);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);

  // One iteration of each datapath; the guard bit of rem_shift makes the trial
  // subtraction's borrow the quotient-bit decision.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    prod_step = {mul_sum, prod_q[XLEN-1:1]};
    rem_shift = {rem_q, quo_q[XLEN-1]};
    trial     = rem_shift - {1'b0, opnd_q};
    if (trial[XLEN]) begin
      rem_step = rem_shift[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_step = trial[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_DONE;
          case (alu_op)
            4'b0000: result_d = in_a & in_b;
            4'b0001: result_d = in_a | in_b;
            4'b0010: result_d = in_a + in_b;
            4'b0110: result_d = in_a - in_b;
            4'b1000, 4'b1001: begin
              state_d = S_BUSY;
              cnt_d   = '0;
              op_d    = alu_op[1:0];
              opnd_d  = in_a;
              prod_d  = {{XLEN{1'b0}}, in_b};
            end
            4'b1010, 4'b1011: begin
              if (in_b == '0) begin
                result_d = alu_op[0] ? in_a : '1;
              end else begin
                state_d = S_BUSY;
                cnt_d   = '0;
                op_d    = alu_op[1:0];
                opnd_d  = in_b;
                rem_d   = '0;
                quo_d   = in_a;
              end
            end
            default: result_d = '0;
          endcase
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q[1]) begin
          rem_d = rem_step;
          quo_d = quo_step;
        end else begin
          prod_d = prod_step;
        end
        if (cnt_q == LAST_STEP) begin
          state_d = S_DONE;
          case (op_q)
            2'b00:   result_d = prod_step[XLEN-1:0];
            2'b01:   result_d = prod_step[2*XLEN-1:XLEN];
            2'b10:   result_d = quo_step;
            default: result_d = rem_step;
          endcase
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: directed vectors on a 32-bit and an 8-bit instance,
// expected results queued at issue and compared by per-instance monitors.
module tb_iter_alu;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  op32, op8;
  logic [31:0] a32, b32, r32;
  logic [7:0]  a8, b8, r8;
  logic iv32, ir32, ov32, or32, z32, bz32;
  logic iv8,  ir8,  ov8,  or8,  z8,  bz8;

  iter_alu #(.XLEN(32)) u_alu32 (
    .clk(clk), .rst_n(rst_n), .alu_op(op32), .in_a(a32), .in_b(b32),
    .in_valid(iv32), .in_ready(ir32), .result(r32), .zero(z32),
    .out_valid(ov32), .out_ready(or32), .busy(bz32)
  );

  iter_alu #(.XLEN(8)) u_alu8 (
    .clk(clk), .rst_n(rst_n), .alu_op(op8), .in_a(a8), .in_b(b8),
    .in_valid(iv8), .in_ready(ir8), .result(r8), .zero(z8),
    .out_valid(ov8), .out_ready(or8), .busy(bz8)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] q32[$];
  logic [7:0]  q8[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  function automatic logic get_ir(input bit w8);
    return w8 ? ir8 : ir32;
  endfunction
  function automatic logic get_ov(input bit w8);
    return w8 ? ov8 : ov32;
  endfunction
  function automatic logic get_busy(input bit w8);
    return w8 ? bz8 : bz32;
  endfunction

  task automatic drive(input bit w8, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      iv8 = v; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      iv32 = v; op32 = op; a32 = a; b32 = b;
    end
  endtask

  task automatic set_ordy(input bit w8, input logic v);
    if (w8) or8 = v;
    else    or32 = v;
  endtask

  // Monitors: compare the queue head every cycle out_valid is up, pop on handshake.
  always @(negedge clk) begin
    if (rst_n && ov32) begin
      if (q32.size() == 0) check("unexpected out_valid 32", 32'(ov32), 32'd0);
      else begin
        check("result 32", r32, q32[0]);
        check("zero 32", 32'(z32), 32'(q32[0] == 32'd0));
        if (or32) void'(q32.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov8) begin
      if (q8.size() == 0) check("unexpected out_valid 8", 32'(ov8), 32'd0);
      else begin
        check("result 8", 32'(r8), 32'(q8[0]));
        check("zero 8", 32'(z8), 32'(q8[0] == 8'd0));
        if (or8) void'(q8.pop_front());
      end
    end
  end

  // One transaction: issue, measure latency and busy cycles, optional backpressure,
  // optional in_valid chatter with changing ops while the request is in flight.
  task automatic run(input string name, input bit w8, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                     input int hold, input bit chatter);
    int xlen;
    logic [31:0] bm;
    bit iter;
    int exp_lat, lat, busy_n, w;
    xlen    = w8 ? 8 : 32;
    bm      = w8 ? {24'b0, b[7:0]} : b;
    iter    = (op == 4'b1000) || (op == 4'b1001) ||
              (((op == 4'b1010) || (op == 4'b1011)) && (bm != 32'd0));
    exp_lat = iter ? xlen + 1 : 1;

    drive(w8, 1'b1, op, a, b);
    w = 0;
    while (!get_ir(w8) && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check({name, " in_ready before accept"}, 32'(get_ir(w8)), 32'd1);
    if (w8) q8.push_back(exp[7:0]);
    else    q32.push_back(exp);
    @(posedge clk); #1;
    if (chatter) drive(w8, 1'b1, 4'b0010, 32'hDEAD_BEEF, 32'h1111_1111);
    else         drive(w8, 1'b0, 4'b0000, 32'd0, 32'd0);

    lat = 1;
    busy_n = 0;
    while (!get_ov(w8) && lat <= 100) begin
      if (get_busy(w8)) busy_n++;
      @(posedge clk); #1;
      lat++;
      if (chatter) drive(w8, 1'b1, 4'(lat), ~a, ~b);
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " busy cycles"}, 32'(busy_n), iter ? 32'(xlen) : 32'd0);

    for (int i = 0; i < hold; i++) begin
      check({name, " in_ready low while done"}, 32'(get_ir(w8)), 32'd0);
      @(posedge clk); #1;
    end
    set_ordy(w8, 1'b1);
    @(posedge clk); #1;
    set_ordy(w8, 1'b0);
    check({name, " out_valid drops"}, 32'(get_ov(w8)), 32'd0);
    check({name, " in_ready rises"}, 32'(get_ir(w8)), 32'd1);
    drive(w8, 1'b0, 4'b0000, 32'd0, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
    or32 = 1'b0;
    or8  = 1'b0;
    #1;
    check("reset result", r32, 32'd0);
    check("reset zero", 32'(z32), 32'd1);
    check("reset out_valid", 32'(ov32), 32'd0);
    check("reset in_ready", 32'(ir32), 32'd1);
    check("reset busy", 32'(bz32), 32'd0);
    check("reset out_valid 8", 32'(ov8), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset during BUSY discards the pending multiply.
    drive(1'b0, 1'b1, 4'b1000, 32'hFFFF_FFFF, 32'd2);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(ov32), 32'd0);
    check("midreset result", r32, 32'd0);
    check("midreset zero", 32'(z32), 32'd1);
    check("midreset in_ready", 32'(ir32), 32'd1);
    check("midreset busy", 32'(bz32), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("add after reset", 1'b0, 4'b0010, 32'd5, 32'd7, 32'd12, 0, 1'b0);

    // Fast ops.
    run("add wrap", 1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1'b0);
    run("sub", 1'b0, 4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 1'b0);
    run("and hold", 1'b0, 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 5, 1'b0);
    run("or", 1'b0, 4'b0001, 32'h1, 32'h2, 32'h3, 0, 1'b0);
    run("undef op", 1'b0, 4'b0101, 32'h1234, 32'h5678, 32'd0, 0, 1'b0);

    // Multiply; the first one has in_valid chattering while busy and done.
    run("mul chatter", 1'b0, 4'b1000, 32'h1234_5678, 32'h10, 32'h2345_6780, 3, 1'b1);
    run("mulhu", 1'b0, 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b0);
    run("mul zero", 1'b0, 4'b1000, 32'd0, 32'd5, 32'd0, 0, 1'b0);

    // Divide and divide by zero.
    run("divu", 1'b0, 4'b1010, 32'd100, 32'd7, 32'd14, 0, 1'b0);
    run("remu", 1'b0, 4'b1011, 32'd100, 32'd7, 32'd2, 0, 1'b0);
    run("divu msb", 1'b0, 4'b1010, 32'h8000_0000, 32'd1, 32'h8000_0000, 0, 1'b0);
    run("remu exact", 1'b0, 4'b1011, 32'd6, 32'd3, 32'd0, 2, 1'b0);
    run("divu by0", 1'b0, 4'b1010, 32'h1234, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
    run("remu by0", 1'b0, 4'b1011, 32'h1234, 32'd0, 32'h1234, 0, 1'b0);

    // 8-bit instance.
    run("mul8", 1'b1, 4'b1000, 32'hFF, 32'hFF, 32'h01, 0, 1'b0);
    run("mulhu8", 1'b1, 4'b1001, 32'hFF, 32'hFF, 32'hFE, 0, 1'b1);
    run("divu8", 1'b1, 4'b1010, 32'd100, 32'd7, 32'd14, 0, 1'b0);
    run("remu8", 1'b1, 4'b1011, 32'd100, 32'd7, 32'd2, 0, 1'b0);
    run("divu8 msb", 1'b1, 4'b1010, 32'h80, 32'd1, 32'h80, 0, 1'b0);
    run("remu8 exact", 1'b1, 4'b1011, 32'd6, 32'd3, 32'd0, 0, 1'b0);
    run("divu8 by0", 1'b1, 4'b1010, 32'h34, 32'd0, 32'hFF, 0, 1'b0);
    run("remu8 by0", 1'b1, 4'b1011, 32'h34, 32'd0, 32'h34, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue 32 drained", 32'(q32.size()), 32'd0);
    check("queue 8 drained", 32'(q8.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
